// File: rtl/dc_fifo_pkg.sv
// Shared definitions for both controllers of the dual-clock token-ring FIFO:
// one-hot pointer helpers and default geometry.
package dc_fifo_pkg;

   localparam int DEFAULT_BUFFER_DEPTH = 8;
   localparam int DEFAULT_SYNC_STAGES  = 2;

   // Helpers operate on a fixed wide vector; callers zero-extend in and truncate out.
   localparam int MAX_PTR_WIDTH = 64;

   function automatic logic [MAX_PTR_WIDTH-1:0] onehot_rotl(
      input logic [MAX_PTR_WIDTH-1:0] ptr,
      input int                       width
   );
      logic [MAX_PTR_WIDTH-1:0] mask;
      mask        = (MAX_PTR_WIDTH'(1) << width) - MAX_PTR_WIDTH'(1);
      onehot_rotl = ((ptr << 1) | (ptr >> (width - 1))) & mask;
   endfunction

   function automatic logic is_onehot(input logic [MAX_PTR_WIDTH-1:0] v);
      is_onehot = (v != '0) && ((v & (v - MAX_PTR_WIDTH'(1))) == '0);
   endfunction

endpackage

// File: rtl/dc_ptr_synchronizer.sv
// Per-bit multi-flop synchronizer for a one-hot pointer crossing clock domains.
// Every stage resets to RESET_VALUE so the far side sees a legal pointer at once.
module dc_ptr_synchronizer
   import dc_fifo_pkg::*;
#(
   parameter int               WIDTH       = DEFAULT_BUFFER_DEPTH,
   parameter int               SYNC_STAGES = DEFAULT_SYNC_STAGES,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] data_async,
   output logic [WIDTH-1:0] data_sync
);

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= RESET_VALUE;
         end
      end else begin
         sync_q[0] <= data_async;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign data_sync = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dc_fifo_write_ctrl.sv
// Write-side controller of the dual-clock token-ring FIFO: owns the one-hot
// write pointer and flags full against the synchronized read pointer.
module dc_fifo_write_ctrl
   import dc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
   parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    valid_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   output logic                    ready_o,
   input  logic [BUFFER_DEPTH-1:0] read_pointer_async,
   output logic [BUFFER_DEPTH-1:0] write_pointer,
   output logic [DATA_WIDTH-1:0]   write_data,
   output logic                    full_o
);

   logic [BUFFER_DEPTH-1:0] r_sync;
   logic [BUFFER_DEPTH-1:0] next_pointer;
   logic                    full;
   logic                    accept;

   dc_ptr_synchronizer #(
      .WIDTH       (BUFFER_DEPTH),
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VALUE (BUFFER_DEPTH'(1))
   ) u_read_ptr_sync (
      .clk        (clk),
      .rstn       (rstn),
      .data_async (read_pointer_async),
      .data_sync  (r_sync)
   );

   assign next_pointer = BUFFER_DEPTH'(onehot_rotl(MAX_PTR_WIDTH'(write_pointer), BUFFER_DEPTH));

   // One slot stays spare; an all-zero r_sync means a read-token move is in flight.
   assign full = (r_sync == '0) || ((next_pointer & r_sync) != '0);

   // Handshake: a word transfers on a rising clk edge when valid_i && ready_o.
   // ready_o depends only on registered state, never on valid_i; valid_i may
   // drop without a transfer, and data_i must be stable only in the transfer cycle.
   assign ready_o    = ~full;
   assign full_o     = full;
   assign accept     = valid_i && ready_o;
   assign write_data = data_i;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         write_pointer <= BUFFER_DEPTH'(1);
      end else if (accept) begin
         write_pointer <= next_pointer;
      end
   end

endmodule

// File: doc/dc_fifo_write_ctrl.md
Name: dc_fifo_write_ctrl

Overview:
Write-side controller of the dual-clock token-ring FIFO. It accepts a valid/ready stream in the write clock domain, steers the data into the shared data buffer and owns the one-hot write pointer, which rotates once per accepted word. It synchronizes the one-hot read pointer from the read clock domain and derives a conservative full flag, so the buffer is never overrun. Its outputs drive the buffer's write_pointer and write_data inputs directly.

Parameters:
DATA_WIDTH, 32, payload width in bits.
BUFFER_DEPTH, 8, number of buffer slots; one-hot pointer width; must be >= 3.
SYNC_STAGES, 2, flop stages per read-pointer bit in the synchronizer; must be >= 2.

Ports:
clk  in  1  write-domain clock.
rstn  in  1  asynchronous active-low reset.
valid_i  in  1  upstream word valid.
data_i  in  DATA_WIDTH  upstream payload.
ready_o  out  1  controller can accept a word this cycle.
read_pointer_async  in  BUFFER_DEPTH  one-hot read pointer from the read domain; asynchronous to clk.
write_pointer  out  BUFFER_DEPTH  one-hot write slot to the data buffer.
write_data  out  DATA_WIDTH  data to the buffer.
full_o  out  1  status; equals ~ready_o.

Behaviour:
- Reset: rstn is asynchronous and active-low; clock is clk. Reset values: write_pointer = 1 (slot 0), every synchronizer stage = 1, so ready_o = 1 and full_o = 0.
- write_data = data_i, combinational. The buffer overwrites the slot at write_pointer every cycle. The word on the edge where the pointer advances is the one kept.
- Accept: a word is accepted on a rising edge when valid_i && ready_o. The write pointer advances on that same edge. Zero-cycle latency from accept to slot write.
- Pointer advance: write_pointer <= rotate-left-by-1(write_pointer). Bit BUFFER_DEPTH-1 wraps to bit 0. There is no other pointer update.
- ready_o must not depend combinationally on valid_i. valid_i may drop without being accepted. data_i need only be stable in the accepting cycle.
- Synchronizer: each bit of read_pointer_async passes independently through SYNC_STAGES flops. The last stage is r_sync.
- Full detection (registered inputs only):
  - full_o = 1 if (rotl(write_pointer) & r_sync) != 0, i.e. one slot is kept spare.
  - Also full_o = 1 when r_sync == 0, which occurs transiently while a read-token move is in flight.
- Two set bits in r_sync (old and new read position seen simultaneously) need no special case. Either match gives full.
- The full flag is conservative. Read progress is seen SYNC_STAGES to SYNC_STAGES+1 clk cycles late. This may delay ready_o but never causes an overwrite of an unread slot.
- Once full_o rises, it stays high until r_sync shows the read pointer has moved past rotl(write_pointer).
- At full, write_pointer sits one slot behind the read pointer. At empty, write_pointer equals the read pointer; no emptiness logic is needed on this side.
- Reset mid-operation: all state returns to the reset values immediately and asynchronously, regardless of valid_i. Both FIFO sides must be reset together; that is the system's responsibility.
- Assertions in the bench:
  - write_pointer is always one-hot.
  - The pointer never advances while ready_o = 0.

Decomposition:
- Package dc_fifo_pkg holds:
  - a function for one-hot rotate-left;
  - a function that checks a one-hot vector for validity;
  - the default depth and sync-stage constants shared with the read-side controller.
- One sub-module, dc_ptr_synchronizer (parameters WIDTH, SYNC_STAGES). It is a per-bit flop chain with asynchronous reset to a parameterized value (here 1). The read side reuses it for the write pointer.

Test Plan:
- Reset, DEPTH=8: hold rstn low -> write_pointer=8'h01, ready_o=1, full_o=0. Release -> unchanged with valid_i=0.
- Fill, read_pointer_async held at 8'h01, valid_i=1, data_i=0xA0..0xA6 -> 7 accepts. write_pointer steps 02,04,…,80, then ready_o=0. The buffer holds A0..A6 in slots 0..6; the 8th word is held off.
- Drain visibility, from full: set read_pointer_async=8'h02 -> ready_o=1 two to three cycles later. One more accept -> write_pointer wraps 80->01, ready_o=0 again.
- Token transient: from a non-full state, drive read_pointer_async=8'h00 for 5 cycles -> full_o=1 from the 2nd/3rd cycle. Restoring 8'h01 -> ready_o returns 1 after the sync delay, and write_pointer is unchanged throughout.
- Bursty valid: toggle valid_i every cycle with read_pointer_async free-running ahead -> exactly one pointer rotation per valid&&ready cycle, and 0 rotations on valid_i=0 cycles.
- Reset mid-burst: assert rstn low at write_pointer=8'h10 with valid_i=1 -> write_pointer=8'h01 and ready_o=1 asynchronously, before the next edge.
